// File: rtl/nco_accum_if.sv
// Control/phase bus of the NCO core: byte-wide register writes, commit/sync/enable strobes,
// packed phase words and per-channel wrap pulses. No handshake; everything sampled every edge.
interface nco_accum_if #(
  parameter int NCH   = 2,
  parameter int OUT_W = 8
);
  logic                   en;
  logic [7:0]             data;
  logic                   wr;
  logic [7:0]             addr;
  logic                   commit;
  logic                   sync;
  logic [NCH*OUT_W-1:0]   phase;
  logic [NCH-1:0]         wrap;

  modport master (
    output en, data, wr, addr, commit, sync,
    input  phase, wrap
  );

  modport slave (
    input  en, data, wr, addr, commit, sync,
    output phase, wrap
  );
endinterface

// File: rtl/nco_accum.sv
// Multi-channel NCO phase accumulator with double-buffered increment/offset; commit-to-phase 2 clocks.
// No backpressure: writes, commit, sync and en are sampled every edge; phase/wrap are registered.
module nco_accum #(
  parameter int NCH   = 2,
  parameter int ACC_W = 24,
  parameter int OUT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  nco_accum_if.slave bus
);
  localparam int NB = ACC_W / 8;

  typedef logic [ACC_W-1:0] word_t;

  word_t sh_inc_q  [NCH];
  word_t sh_inc_d  [NCH];
  word_t sh_off_q  [NCH];
  word_t sh_off_d  [NCH];
  word_t act_inc_q [NCH];
  word_t act_inc_d [NCH];
  word_t act_off_q [NCH];
  word_t act_off_d [NCH];
  word_t acc_q     [NCH];
  word_t acc_d     [NCH];

  logic [NCH-1:0]       carry_q, carry_d;
  logic [NCH-1:0]       wrap_q, wrap_d;
  logic [NCH*OUT_W-1:0] phase_q, phase_d;

  logic [ACC_W:0]       sum;
  word_t                pos;
  logic [31:0]          addr_w;

  always_comb begin
    sh_inc_d  = sh_inc_q;
    sh_off_d  = sh_off_q;
    act_inc_d = act_inc_q;
    act_off_d = act_off_q;
    acc_d     = acc_q;
    carry_d   = '0;
    wrap_d    = carry_q;
    phase_d   = phase_q;
    sum       = '0;
    pos       = '0;
    addr_w    = {24'd0, bus.addr};

    // Commit takes the pre-write shadow; a same-cycle write still lands in the shadow below.
    if (bus.commit) begin
      act_inc_d = sh_inc_q;
      act_off_d = sh_off_q;
    end

    for (int c = 0; c < NCH; c++) begin
      // Addresses past the last channel match nothing and are dropped.
      for (int b = 0; b < NB; b++) begin
        if (bus.wr && addr_w == 32'(c*2*NB + b))
          sh_inc_d[c][b*8 +: 8] = bus.data;
        if (bus.wr && addr_w == 32'(c*2*NB + NB + b))
          sh_off_d[c][b*8 +: 8] = bus.data;
      end

      sum = {1'b0, acc_q[c]} + {1'b0, act_inc_q[c]};
      if (bus.sync) begin
        acc_d[c] = '0;
      end else if (bus.en) begin
        acc_d[c]   = sum[ACC_W-1:0];
        carry_d[c] = sum[ACC_W];
      end

      // Offset is applied every cycle so an offset commit shows even while frozen.
      pos = acc_q[c] + act_off_q[c];
      phase_d[c*OUT_W +: OUT_W] = OUT_W'(pos >> (ACC_W - OUT_W));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        sh_inc_q[c]  <= '0;
        sh_off_q[c]  <= '0;
        act_inc_q[c] <= '0;
        act_off_q[c] <= '0;
        acc_q[c]     <= '0;
      end
      carry_q <= '0;
      wrap_q  <= '0;
      phase_q <= '0;
    end else begin
      sh_inc_q  <= sh_inc_d;
      sh_off_q  <= sh_off_d;
      act_inc_q <= act_inc_d;
      act_off_q <= act_off_d;
      acc_q     <= acc_d;
      carry_q   <= carry_d;
      wrap_q    <= wrap_d;
      phase_q   <= phase_d;
    end
  end

  assign bus.phase = phase_q;
  assign bus.wrap  = wrap_q;
endmodule

// File: tb/tb_nco_accum.sv
// Directed bench for nco_accum (NCH=2, ACC_W=24, OUT_W=8) with hand-computed phase/wrap values.
module tb_nco_accum;
  localparam int NCH   = 2;
  localparam int ACC_W = 24;
  localparam int OUT_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nco_accum_if #(.NCH(NCH), .OUT_W(OUT_W)) bus ();

  nco_accum #(.NCH(NCH), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] prev0, prev1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ph(input int c);
    return bus.phase[c*OUT_W +: OUT_W];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.en = 1'b0; bus.wr = 1'b0; bus.commit = 1'b0; bus.sync = 1'b0;
    bus.addr = 8'h00; bus.data = 8'h00;
  endtask

  task automatic wr_byte(input logic [7:0] a, input logic [7:0] d);
    bus.addr = a; bus.data = d; bus.wr = 1'b1;
    step();
    bus.wr = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rebase();
    prev0 = ph(0);
    prev1 = ph(1);
  endtask

  // Steps n clocks and checks the per-clock phase advance of both channels.
  task automatic steps_diff(input int n, input logic [7:0] e0, input logic [7:0] e1, input string tag);
    logic [7:0] d0, d1;
    for (int i = 0; i < n; i++) begin
      step();
      d0 = ph(0) - prev0;
      d1 = ph(1) - prev1;
      chk({tag, "_d0"}, d0, e0);
      chk({tag, "_d1"}, d1, e1);
      rebase();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    idle();
    #12;
    chk("rst_phase", bus.phase, 0);
    chk("rst_wrap", bus.wrap, 0);
    bus.en = 1'b1;
    step();
    chk("rst_phase_edge", bus.phase, 0);
    rst_n = 1'b1;
    bus.en = 1'b0;

    // Reset and step: ch0 inc = 0x010000
    wr_byte(8'd2, 8'h01);
    bus.en = 1'b1; bus.commit = 1'b1;
    step();
    bus.commit = 1'b0;
    chk("step_k0", ph(0), 8'h00);
    step();
    chk("step_k1", ph(0), 8'h00);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("step_ph0", ph(0), 32'(i + 1));
      chk("step_ph1", ph(1), 8'h00);
    end

    // Shadow isolation
    wr_byte(8'd2, 8'h02);
    rebase();
    steps_diff(10, 8'd1, 8'd0, "iso_hold");
    bus.addr = 8'd2; bus.data = 8'h04; bus.wr = 1'b1; bus.commit = 1'b1;
    steps_diff(1, 8'd1, 8'd0, "iso_c0");
    bus.wr = 1'b0; bus.commit = 1'b0;
    steps_diff(1, 8'd1, 8'd0, "iso_c1");
    steps_diff(3, 8'd2, 8'd0, "iso_step2");
    bus.commit = 1'b1;
    steps_diff(1, 8'd2, 8'd0, "iso_c2");
    bus.commit = 1'b0;
    steps_diff(1, 8'd2, 8'd0, "iso_c3");
    steps_diff(3, 8'd4, 8'd0, "iso_step4");

    // Wrap: ch0 inc = 0x800000
    do_reset();
    wr_byte(8'd2, 8'h80);
    bus.en = 1'b1; bus.commit = 1'b1;
    step();
    bus.commit = 1'b0;
    step();
    for (int i = 0; i < 6; i++) begin
      step();
      chk("wrap_ph0", ph(0), (i % 2 == 0) ? 32'h80 : 32'h00);
      chk("wrap_w0", 32'(bus.wrap[0]), 32'(i % 2));
      chk("wrap_w1", 32'(bus.wrap[1]), 0);
    end

    // Hold: en low freezes phase and suppresses wrap
    bus.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_ph0", ph(0), 8'h80);
      chk("hold_wrap", bus.wrap, 0);
    end

    // Offset and sync
    do_reset();
    wr_byte(8'd2, 8'h01);
    wr_byte(8'd11, 8'h40);
    bus.en = 1'b1; bus.commit = 1'b1;
    step();
    bus.commit = 1'b0;
    chk("off_k0_ph1", ph(1), 8'h00);
    step();
    chk("off_k1_ph1", ph(1), 8'h40);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("off_ph0", ph(0), 32'(i + 1));
      chk("off_ph1", ph(1), 8'h40);
    end
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
    chk("sync_s0", ph(0), 8'h05);
    step();
    chk("sync_s1", ph(0), 8'h00);
    chk("sync_s1_ph1", ph(1), 8'h40);
    step();
    chk("sync_s2", ph(0), 8'h01);
    chk("sync_wrap", bus.wrap, 0);

    // Asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_phase", bus.phase, 0);
    chk("arst_wrap", bus.wrap, 0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_phase", bus.phase, 0);
    end
    bus.commit = 1'b1;
    step();
    bus.commit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_commit", bus.phase, 0);
    end

    // Illegal addresses
    do_reset();
    wr_byte(8'd2, 8'h01);
    wr_byte(8'd8, 8'h02);
    bus.en = 1'b1; bus.commit = 1'b1;
    step();
    bus.commit = 1'b0;
    step();
    step();
    chk("ill_ph0", ph(0), 8'h01);
    chk("ill_ph1", ph(1), 8'h02);
    wr_byte(8'd12, 8'hFF);
    wr_byte(8'd14, 8'hFF);
    wr_byte(8'hFF, 8'hFF);
    rebase();
    bus.commit = 1'b1;
    steps_diff(1, 8'd1, 8'd2, "ill_c");
    bus.commit = 1'b0;
    steps_diff(6, 8'd1, 8'd2, "ill_run");
    chk("ill_wrap", bus.wrap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
